fazyrv_pc_seq: RTL and testbench

Sequencer for the bit-serial program-counter register in the FazyRV core. On a request from core control it runs one full 32-bit rotation of the PC register in BWIDTH-bit chunks, LSB first. It drives the PC register's `shift`, `inc` and `din` inputs and selects the next-PC source: PC+4, serial jump target, latched trap vector, or hold. It sits between the core control FSM and the PC register, and signals completion and target misalignment back to control.

---
 rtl/fazyrv_pc_seq_if.sv | 32 +++
 rtl/fazyrv_pc_seq.sv | 117 +++++++++++
 tb/tb_fazyrv_pc_seq.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fazyrv_pc_seq_if.sv
// Handshake and serial-datapath bundle between core control,
// the PC register and the PC rotation sequencer.
interface fazyrv_pc_seq_if #(
    parameter int BWIDTH = 8
);
    logic              start_i;
    logic [1:0]        sel_i;
    logic [BWIDTH-1:0] tgt_ser_i;
    logic [31:0]       mtvec_i;
    logic [BWIDTH-1:0] pc_ser_i;
    logic [BWIDTH-1:0] pc_ser_inc_i;
    logic              pc_shift_o;
    logic              pc_inc_o;
    logic [BWIDTH-1:0] pc_din_o;
    logic              ready_o;
    logic              done_o;
    logic              misalign_o;

    modport slave (
        input  start_i, sel_i, tgt_ser_i, mtvec_i,
        input  pc_ser_i, pc_ser_inc_i,
        output pc_shift_o, pc_inc_o, pc_din_o,
        output ready_o, done_o, misalign_o
    );

    modport master (
        output start_i, sel_i, tgt_ser_i, mtvec_i,
        output pc_ser_i, pc_ser_inc_i,
        input  pc_shift_o, pc_inc_o, pc_din_o,
        input  ready_o, done_o, misalign_o
    );
endinterface

// File: rtl/fazyrv_pc_seq.sv
// Runs one 32-bit rotation of the bit-serial PC register, LSB
// chunk first, selecting PC+4, jump target, trap vector or hold.
module fazyrv_pc_seq #(
    parameter int BWIDTH = 8
) (
    input logic             clk_i,
    input logic             rst_in,
    fazyrv_pc_seq_if.slave  bus
);
    localparam int CHUNKS = 32 / BWIDTH;
    localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);
    localparam int MB = (BWIDTH > 1) ? 1 : 0;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {
        SEL_PC4, SEL_JUMP, SEL_TRAP, SEL_HOLD
    } sel_t;

    state_t      state_q;
    sel_t        sel_q;
    logic [CW-1:0] cnt_q;
    logic        mis_q;
    logic [31:0] vec_q;
    logic        ready_q, shift_q, inc_q, done_q, misout_q;

    logic              mis_hit;
    logic [BWIDTH-1:0] keep1, keep2;
    logic [BWIDTH-1:0] din;

    // Target bit1 arrives in chunk 0, or alone in chunk 1 when serial.
    if (BWIDTH == 1) begin : g_mis1
        assign mis_hit = (cnt_q == CW'(1)) & bus.tgt_ser_i[0];
    end else begin : g_misn
        assign mis_hit = (cnt_q == '0) & bus.tgt_ser_i[MB];
    end

    always_comb begin
        keep1 = '1;
        keep2 = '1;
        for (int j = 0; j < BWIDTH; j++) begin
            if (int'(cnt_q) * BWIDTH + j < 1) keep1[j] = 1'b0;
            if (int'(cnt_q) * BWIDTH + j < 2) keep2[j] = 1'b0;
        end
    end

    always_comb begin
        din = '0;
        if (state_q == SHIFT) begin
            unique case (sel_q)
                SEL_PC4:  din = bus.pc_ser_inc_i;
                SEL_JUMP: din = bus.tgt_ser_i & keep1;
                SEL_TRAP: din = vec_q[BWIDTH-1:0] & keep2;
                SEL_HOLD: din = bus.pc_ser_i;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q  <= IDLE;
            sel_q    <= SEL_PC4;
            cnt_q    <= '0;
            mis_q    <= 1'b0;
            vec_q    <= '0;
            ready_q  <= 1'b1;
            shift_q  <= 1'b0;
            inc_q    <= 1'b0;
            done_q   <= 1'b0;
            misout_q <= 1'b0;
        end else begin
            inc_q    <= 1'b0;
            done_q   <= 1'b0;
            misout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    shift_q <= 1'b0;
                    if (bus.start_i) begin
                        state_q <= SHIFT;
                        sel_q   <= sel_t'(bus.sel_i);
                        vec_q   <= bus.mtvec_i;
                        cnt_q   <= '0;
                        mis_q   <= 1'b0;
                        ready_q <= 1'b0;
                        shift_q <= 1'b1;
                        inc_q   <= (bus.sel_i == 2'd0);
                    end
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    vec_q <= vec_q >> BWIDTH;
                    if (sel_q == SEL_JUMP && mis_hit) mis_q <= 1'b1;
                    if (cnt_q == LAST) begin
                        state_q  <= DONE;
                        shift_q  <= 1'b0;
                        done_q   <= 1'b1;
                        misout_q <= mis_q
                            | ((sel_q == SEL_JUMP) & mis_hit);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.pc_shift_o = shift_q;
    assign bus.pc_inc_o   = inc_q;
    assign bus.pc_din_o   = din;
    assign bus.ready_o    = ready_q;
    assign bus.done_o     = done_q;
    assign bus.misalign_o = misout_q;
endmodule

// File: tb/tb_fazyrv_pc_seq.sv
// Bench for fazyrv_pc_seq: one instance per BWIDTH (1,2,4,8), each
// with a behavioural PC register; expected PCs queued at accept.
module tb_fazyrv_pc_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]       rst_v, start_v, ld_v;
    logic [3:0][1:0]  sel_v;
    logic [3:0][31:0] mtvec_v, tgt_v, pcv;
    logic [3:0]       shift_v, inc_v, ready_v, done_v, mis_v;
    logic [3:0][7:0]  din_v;
    logic [31:0]      ld_val;

    typedef struct {
        logic [31:0] pc;
        logic        mis;
    } exp_t;
    exp_t sbq[$];

    int nchk = 0;
    int npass = 0;

    for (genvar i = 0; i < 4; i++) begin : g
        localparam int BW = 1 << i;
        fazyrv_pc_seq_if #(.BWIDTH(BW)) bus ();
        logic [31:0] pc_q, sh_q, p4, tsh;
        logic [5:0]  k_q;

        fazyrv_pc_seq #(.BWIDTH(BW)) dut (
            .clk_i  (clk),
            .rst_in (rst_v[i]),
            .bus    (bus)
        );

        assign p4  = pc_q + 32'd4;
        assign tsh = tgt_v[i] >> (k_q * BW);
        assign bus.start_i      = start_v[i];
        assign bus.sel_i        = sel_v[i];
        assign bus.mtvec_i      = mtvec_v[i];
        assign bus.tgt_ser_i    = tsh[BW-1:0];
        assign bus.pc_ser_i     = pc_q[BW-1:0];
        assign bus.pc_ser_inc_i = bus.pc_inc_o ? p4[BW-1:0]
                                               : sh_q[BW-1:0];

        // Behavioural PC register; sh_q carries the rest of PC+4.
        always @(posedge clk) begin
            if (!rst_v[i]) begin
                pc_q <= 32'h0;
                sh_q <= 32'h0;
                k_q  <= 6'd0;
            end else if (ld_v[i]) begin
                pc_q <= ld_val;
            end else if (bus.pc_shift_o) begin
                pc_q <= {bus.pc_din_o, pc_q[31:BW]};
                sh_q <= (bus.pc_inc_o ? p4 : sh_q) >> BW;
                k_q  <= k_q + 6'd1;
            end else begin
                k_q <= 6'd0;
            end
        end

        assign pcv[i]     = pc_q;
        assign shift_v[i] = bus.pc_shift_o;
        assign inc_v[i]   = bus.pc_inc_o;
        assign ready_v[i] = bus.ready_o;
        assign done_v[i]  = bus.done_o;
        assign mis_v[i]   = bus.misalign_o;
        assign din_v[i]   = 8'(bus.pc_din_o);
    end

    task automatic load_pc(input int w, input logic [31:0] v);
        @(negedge clk);
        ld_v[w] = 1'b1;
        ld_val  = v;
        @(posedge clk);
        #1 ld_v[w] = 1'b0;
    endtask

    task automatic run_update(
        input int w, input logic [1:0] sel, input logic [31:0] mtvec,
        input logic [31:0] tgt, input logic [31:0] exp_pc,
        input logic exp_mis, input string nm);
        int chunks, nshift, ninc, inc_at, done_at, ndone, nstray;
        exp_t e;
        chunks = 32 >> w;
        nshift = 0; ninc = 0; inc_at = -1;
        done_at = -1; ndone = 0; nstray = 0;
        @(negedge clk);
        nchk++;
        if (ready_v[w] !== 1'b1)
            $display("FAIL %s ready_pre: got %b want 1", nm, ready_v[w]);
        else npass++;
        start_v[w] = 1'b1;
        sel_v[w]   = sel;
        mtvec_v[w] = mtvec;
        tgt_v[w]   = tgt;
        sbq.push_back('{exp_pc, exp_mis});
        @(posedge clk);
        #1;
        start_v[w] = 1'b0;
        sel_v[w]   = ~sel;
        mtvec_v[w] = ~mtvec;
        for (int c = 1; c <= chunks + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                nchk++;
                if (ready_v[w] !== 1'b0)
                    $display("FAIL %s ready_busy: got %b want 0", nm, ready_v[w]);
                else npass++;
            end
            if (shift_v[w]) nshift++;
            if (inc_v[w]) begin ninc++; inc_at = c; end
            if (mis_v[w] && !done_v[w]) nstray++;
            if (done_v[w]) begin
                ndone++;
                done_at = c;
                nchk++;
                if (sbq.size() == 0) begin
                    $display("FAIL %s scoreboard: got done, want none queued", nm);
                end else begin
                    e = sbq.pop_front();
                    if (pcv[w] !== e.pc || mis_v[w] !== e.mis)
                        $display("FAIL %s pc/mis: got %h/%b want %h/%b",
                                 nm, pcv[w], mis_v[w], e.pc, e.mis);
                    else npass++;
                end
            end
            if (c == chunks + 2) begin
                nchk++;
                if (ready_v[w] !== 1'b1)
                    $display("FAIL %s ready_post: got %b want 1", nm, ready_v[w]);
                else npass++;
            end
        end
        nchk++;
        if (nshift != chunks || nstray != 0)
            $display("FAIL %s shifts/stray: got %0d/%0d want %0d/0",
                     nm, nshift, nstray, chunks);
        else npass++;
        nchk++;
        if (ninc != (sel == 2'd0 ? 1 : 0) || inc_at != (sel == 2'd0 ? 1 : -1))
            $display("FAIL %s inc: got %0d at %0d want %0d",
                     nm, ninc, inc_at, sel == 2'd0 ? 1 : 0);
        else npass++;
        nchk++;
        if (ndone != 1 || done_at != chunks + 1)
            $display("FAIL %s done: got %0d at %0d want 1 at %0d",
                     nm, ndone, done_at, chunks + 1);
        else npass++;
    endtask

    task automatic test_reset();
        rst_v = 4'h0; start_v = 4'h0; ld_v = 4'h0; ld_val = '0;
        sel_v = '0; mtvec_v = '0; tgt_v = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nchk++;
        if (ready_v !== 4'hF || shift_v !== 4'h0 || inc_v !== 4'h0 ||
            done_v !== 4'h0 || mis_v !== 4'h0 || din_v !== '0)
            $display("FAIL reset: got rdy%h sh%h inc%h dn%h mis%h din%h want F/0/0/0/0/0",
                     ready_v, shift_v, inc_v, done_v, mis_v, din_v);
        else npass++;
        rst_v = 4'hF;
    endtask

    task automatic test_pc4();
        load_pc(3, 32'h0000_0100);
        run_update(3, 2'd0, 32'h0, 32'h0, 32'h0000_0104, 1'b0, "pc4_b8");
    endtask

    task automatic test_jump();
        for (int w = 0; w < 4; w++) begin
            load_pc(w, 32'h0000_0040);
            run_update(w, 2'd1, 32'h0, 32'h0000_2003,
                       32'h0000_2002, 1'b1, "jump_mis");
        end
        run_update(3, 2'd1, 32'h0, 32'h0000_2001,
                   32'h0000_2000, 1'b0, "jump_ok_b8");
        run_update(0, 2'd1, 32'h0, 32'hC000_0005,
                   32'hC000_0004, 1'b0, "jump_ok_b1");
    endtask

    task automatic test_trap();
        load_pc(0, 32'h1234_5678);
        run_update(0, 2'd2, 32'h8000_0007, 32'hFFFF_FFFF,
                   32'h8000_0004, 1'b0, "trap_b1");
        run_update(2, 2'd2, 32'hA5A5_5A5B, 32'h0,
                   32'hA5A5_5A58, 1'b0, "trap_b4");
    endtask

    task automatic test_wrap_hold();
        load_pc(2, 32'hFFFF_FFFC);
        run_update(2, 2'd0, 32'h0, 32'h0, 32'h0000_0000, 1'b0, "wrap_b4");
        run_update(2, 2'd3, 32'h0, 32'hFFFF_FFFF,
                   32'h0000_0000, 1'b0, "hold_b4");
        load_pc(1, 32'hDEAD_BEEF);
        run_update(1, 2'd3, 32'h0, 32'h0, 32'hDEAD_BEEF, 1'b0, "hold_b2");
    endtask

    task automatic test_back_to_back();
        int na, nd, last, prevd;
        logic [31:0] expv;
        exp_t e;
        na = 0; nd = 0; last = -1; prevd = 0;
        expv = 32'h0000_0010;
        load_pc(1, expv);
        @(negedge clk);
        start_v[1] = 1'b1;
        sel_v[1]   = 2'd0;
        for (int c = 0; c < 80; c++) begin
            if (done_v[1]) begin
                nd++;
                nchk++;
                if (prevd != 0 || (last >= 0 && c - last != 18))
                    $display("FAIL b2b spacing: got %0d want 18", c - last);
                else npass++;
                last = c;
                nchk++;
                if (sbq.size() == 0) begin
                    $display("FAIL b2b scoreboard: got done, want none queued");
                end else begin
                    e = sbq.pop_front();
                    if (pcv[1] !== e.pc)
                        $display("FAIL b2b pc: got %h want %h", pcv[1], e.pc);
                    else npass++;
                end
            end
            prevd = done_v[1];
            if (ready_v[1] && start_v[1]) begin
                expv = expv + 32'd4;
                sbq.push_back('{expv, 1'b0});
                na++;
            end
            @(posedge clk);
            #1 if (na == 3) start_v[1] = 1'b0;
            @(negedge clk);
        end
        nchk++;
        if (nd != 3 || sbq.size() != 0)
            $display("FAIL b2b count: got %0d dones %0d left want 3/0",
                     nd, sbq.size());
        else npass++;
    endtask

    task automatic test_reset_mid();
        int nbad;
        nbad = 0;
        @(negedge clk);
        start_v[3] = 1'b1;
        sel_v[3]   = 2'd1;
        tgt_v[3]   = 32'h0000_2003;
        @(posedge clk);
        #1 start_v[3] = 1'b0;
        repeat (3) @(negedge clk);
        rst_v[3] = 1'b0;
        @(negedge clk);
        rst_v[3] = 1'b1;
        nchk++;
        if (ready_v[3] !== 1'b1 || shift_v[3] !== 1'b0 ||
            done_v[3] !== 1'b0 || mis_v[3] !== 1'b0)
            $display("FAIL rst_mid: got rdy%b sh%b dn%b mis%b want 1/0/0/0",
                     ready_v[3], shift_v[3], done_v[3], mis_v[3]);
        else npass++;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done_v[3] || mis_v[3] || shift_v[3]) nbad++;
        end
        nchk++;
        if (nbad != 0)
            $display("FAIL rst_mid quiet: got %0d pulses want 0", nbad);
        else npass++;
        run_update(3, 2'd0, 32'h0, 32'h0, 32'h0000_0004, 1'b0, "boot_pc4");
    endtask

    initial begin
        test_reset();
        test_pc4();
        test_jump();
        test_trap();
        test_wrap_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
